// File: rtl/preg_release_unit.sv
// Stages stale physical registers freed at commit and returns them one per
// cycle to the free-register queue, in retirement order, never dropping any.
module preg_release_unit #(
  parameter int COMMIT_WIDTH = 2,
  parameter int BUF_DEPTH    = 8,
  parameter int PREG_W       = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [COMMIT_WIDTH-1:0]        commit_valid,
  input  logic [COMMIT_WIDTH-1:0]        commit_has_dest,
  input  logic [COMMIT_WIDTH*PREG_W-1:0] commit_old_preg,
  output logic                           release_ready,
  input  logic                           free_full,
  output logic                           free_w_en,
  output logic [PREG_W-1:0]              free_preg,
  output logic [$clog2(BUF_DEPTH):0]     pending_cnt,
  output logic                           protocol_err
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] WIDTH_C = CW'(COMMIT_WIDTH);

  logic [PREG_W-1:0] buf_q [BUF_DEPTH];
  logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              err_q, err_d;

  logic [PREG_W-1:0]       lane_s     [COMMIT_WIDTH];
  logic [AW-1:0]           slot_idx_s [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] qual_s;
  logic [CW-1:0]           push_cnt_s;
  logic                    push_en_s;
  logic                    pop_s;
  logic                    viol_s;

  // Ready depends only on registered occupancy, so the commit stage sees no
  // combinational path from its own request or from the free queue.
  assign release_ready = (DEPTH_C - count_q) >= WIDTH_C;
  assign push_en_s     = release_ready;
  assign viol_s        = (|commit_valid) & ~release_ready;
  assign pop_s         = (count_q != '0) & ~free_full;

  assign free_w_en    = pop_s;
  assign free_preg    = (count_q != '0) ? buf_q[rd_ptr_q[AW-1:0]] : '0;
  assign pending_cnt  = count_q;
  assign protocol_err = err_q;

  // Qualify lanes and compact them: each lane's slot is wr_ptr plus the
  // number of qualifying older lanes, so skipped lanes leave no holes.
  always_comb begin
    push_cnt_s = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      lane_s[k]     = commit_old_preg[k*PREG_W +: PREG_W];
      qual_s[k]     = commit_valid[k] & commit_has_dest[k] & (lane_s[k] != '0);
      slot_idx_s[k] = wr_ptr_q[AW-1:0] + push_cnt_s[AW-1:0];
      if (qual_s[k]) begin
        push_cnt_s = push_cnt_s + CW'(1);
      end else begin
        push_cnt_s = push_cnt_s;
      end
    end
  end

  // Next-state for pointers, occupancy and the sticky error flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q | viol_s;
    if (push_en_s) begin
      wr_ptr_d = wr_ptr_q + push_cnt_s;
      count_d  = count_q + push_cnt_s;
    end else begin
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + CW'(1);
      count_d  = count_d - CW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Staging storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (push_en_s && qual_s[k]) begin
        buf_q[slot_idx_s[k]] <= lane_s[k];
      end
    end
  end

endmodule

// File: doc/preg_release_unit.md
Name: preg_release_unit

Overview:
Commit-side counterpart to the free physical-register queue. It collects the stale physical registers (old destination mappings) freed by up to COMMIT_WIDTH retiring instructions per cycle and buffers them. It then returns them one per cycle through the free queue's single write port (w_en / preg_in), honouring the free queue's full flag. Freed registers are never dropped, and physical register 0 is never returned.

Parameters:
COMMIT_WIDTH, 2, max instructions retired per cycle (1..4)
BUF_DEPTH, 8, staging buffer entries; power of 2, >= 2*COMMIT_WIDTH
PREG_W, $clog2(`NUM_PREGS) (=7), physical register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
commit_valid  in  COMMIT_WIDTH  per-lane retire valid; lane 0 is oldest
commit_has_dest  in  COMMIT_WIDTH  per-lane: instruction wrote a destination register
commit_old_preg  in  COMMIT_WIDTH*PREG_W  per-lane stale preg; lane k occupies bits [(k+1)*PREG_W-1 : k*PREG_W]
release_ready  out  1  unit can accept a full commit group this cycle
free_full  in  1  full flag from the free queue
free_w_en  out  1  write strobe to the free queue
free_preg  out  PREG_W  preg index to the free queue
pending_cnt  out  $clog2(BUF_DEPTH)+1  current buffer occupancy
protocol_err  out  1  sticky; commit group presented while !release_ready

Behaviour:
- Reset (synchronous, rst=1 at posedge): rd/wr pointers=0, count=0, protocol_err=0.
  - Resulting outputs: free_w_en=0, free_preg=0, pending_cnt=0, release_ready=1.
  - Buffer contents are don't-care.
  - rst has priority over all other inputs in the same cycle.
- Qualifying lane k: commit_valid[k] & commit_has_dest[k] & (commit_old_preg[k] != 0).
- Push:
  - Occurs when release_ready=1.
  - All qualifying lanes are compacted and written in ascending lane order starting at wr_ptr; wr_ptr advances by the number of qualifying lanes (0..COMMIT_WIDTH).
  - Non-qualifying lanes leave no holes.
- release_ready = (BUF_DEPTH - count) >= COMMIT_WIDTH.
  - Combinational from registered count.
  - Independent of the current-cycle pop.
  - No combinational path from commit_* or free_full.
- Protocol violation: any commit_valid bit while release_ready=0.
  - Push is suppressed and the whole group is ignored.
  - protocol_err is set the next cycle and held until rst.
- Pop:
  - free_w_en = (count != 0) & !free_full.
  - free_preg = buf[rd_ptr] when count != 0, else 0.
  - Both are combinational from registered state plus free_full.
  - On free_w_en the entry is consumed at the clock edge and rd_ptr increments by 1.
- Simultaneous push and pop: both take effect. count_next = count + pushed - popped, never exceeding BUF_DEPTH.
- Latency: a preg pushed at edge N with an empty buffer appears as free_preg with free_w_en=1 in cycle N+1, provided free_full=0.
- Ordering: strict FIFO across cycles; within a cycle, lane 0 is released before lane 1, and so on.
- Wrap-around: pointers are $clog2(BUF_DEPTH)+1 bits. Index uses the low bits; full/empty are derived from count. Pointer wrap is transparent.
- free_full held high: no pops; buffer fills; release_ready drops when free space < COMMIT_WIDTH. Nothing is lost.
- pending_cnt = registered count.
- No flush input: committed frees are architectural and survive pipeline flushes. Only rst clears the buffer.

Test Plan:
- Reset, then idle -> release_ready=1, free_w_en=0, pending_cnt=0, protocol_err=0.
- One cycle, COMMIT_WIDTH=2: commit_valid=2'b11, has_dest=2'b11, old_preg lane0=35, lane1=90; free_full=0 -> free_w_en=1 with free_preg=35 at N+1, free_preg=90 at N+2, then free_w_en=0 and pending_cnt=0.
- Lanes valid=2'b11, has_dest=2'b10, lane0=12, lane1=7; then valid=2'b01, old_preg lane0=0 -> only 7 is released, pending_cnt peaks at 1.
- free_full=1 while pushing 2 pregs/cycle (values 1..8) -> after 4 pushes pending_cnt=8 and release_ready=0. Release free_full -> 1..8 emitted in order on 8 consecutive cycles; release_ready returns to 1 when pending_cnt<=6.
- Steady state: push 1 preg/cycle (20..59) with free_full=0 -> pending_cnt stays at 1, output order 20..59, pointers wrap cleanly.
- Assert commit_valid while release_ready=0 -> group ignored, protocol_err=1 next cycle and held. rst mid-drain with pending_cnt=5 -> next cycle pending_cnt=0, free_w_en=0, protocol_err=0.
